// File: rtl/pipelined_cla_adder_if.sv
// Valid/ready stream bundle for pipelined_cla_adder: operation in, result plus flags out.
// master drives operations and out_ready; slave is the adder side.
interface pipelined_cla_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, out, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, out, cout, ovf, zero
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// WIDTH-bit add/subtract from 4-bit CLA groups, one register stage per group, valid/ready stream.
// Define CLA_PIPE_SAT_EN to clamp overflowed results to the signed limit matching a's sign.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH = 16
) (
  input logic                 clk,
  input logic                 rst,
  pipelined_cla_adder_if.slave bus
);
  localparam int N_GRP = int'(WIDTH / 4);

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_width_check
    $error("pipelined_cla_adder: WIDTH must be a multiple of 4 and >= 8");
  end

  // Returns {carry_out, sum[3:0]} for one look-ahead group.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;
    logic       c4;
    p    = x ^ y;
    g    = x & y;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c4, p ^ c};
  endfunction

  // Stage k word: groups 0..k hold sum bits, higher groups still hold operand a.
  logic [WIDTH-1:0] w_q  [N_GRP];
  logic [WIDTH-1:0] w_d  [N_GRP];
  logic [WIDTH-1:0] bx_q [N_GRP-1];
  logic [WIDTH-1:0] bx_d [N_GRP-1];
  logic [4:0]       grp  [N_GRP];
  logic [N_GRP-1:0] c_q, c_d;
  logic [N_GRP-1:0] v_q, v_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] bx_in;
  logic             a_msb, b_msb;
  logic             advance;

  assign advance = ~v_q[N_GRP-1] | bus.out_ready;
  assign bx_in   = bus.sub ? ~bus.b : bus.b;

  always_comb begin
    grp    = '{default: '0};
    w_d    = '{default: '0};
    bx_d   = '{default: '0};
    c_d    = '0;
    v_d    = '0;
    grp[0] = cla4(bus.a[3:0], bx_in[3:0], bus.cin ^ bus.sub);
    w_d[0] = {bus.a[WIDTH-1:4], grp[0][3:0]};
    bx_d[0] = bx_in;
    c_d[0] = grp[0][4];
    v_d[0] = bus.in_valid;
    for (int k = 1; k < N_GRP; k++) begin
      grp[k]          = cla4(w_q[k-1][4*k +: 4], bx_q[k-1][4*k +: 4], c_q[k-1]);
      w_d[k]          = w_q[k-1];
      w_d[k][4*k +: 4] = grp[k][3:0];
      c_d[k]          = grp[k][4];
      v_d[k]          = v_q[k-1];
    end
    for (int k = 1; k < N_GRP - 1; k++) begin
      bx_d[k] = bx_q[k-1];
    end
    // Final group still sees untouched a and b' MSBs in the previous stage.
    a_msb = w_q[N_GRP-2][WIDTH-1];
    b_msb = bx_q[N_GRP-2][WIDTH-1];
    ovf_d = (a_msb == b_msb) & (w_d[N_GRP-1][WIDTH-1] != a_msb);
`ifdef CLA_PIPE_SAT_EN
    if (ovf_d) begin
      w_d[N_GRP-1] = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    zero_d = ~|w_d[N_GRP-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_GRP; k++) w_q[k] <= '0;
      for (int k = 0; k < N_GRP - 1; k++) bx_q[k] <= '0;
      c_q    <= '0;
      v_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < N_GRP; k++) w_q[k] <= w_d[k];
      for (int k = 0; k < N_GRP - 1; k++) bx_q[k] <= bx_d[k];
      c_q    <= c_d;
      v_q    <= v_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = v_q[N_GRP-1];
  assign bus.out       = w_q[N_GRP-1];
  assign bus.cout      = c_q[N_GRP-1];
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule
